// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and helpers for the VGA timing blocks.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int FRAME_W = 8;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Registered raster outputs, all decoded from the same position.
  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               line_start;
    logic               frame_start;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vga_beat_t;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_pix_prescaler.sv
// Divides the system clock into a one-clk pixel strobe; en freezes the phase.
module vga_pix_prescaler #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_pix_ce
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic          w_last;

  assign w_last   = (r_div == DIV_LAST);
  assign o_pix_ce = i_en & w_last;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if (i_en) begin
      r_div <= w_last ? '0 : r_div + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel strobe, h/v counters and registered sync/de/coordinate decode.
// Build option: define VGA_FRAME_COUNTER_EN to implement the frame_cnt counter.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic               w_pix_ce;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic [COORD_W-1:0] w_h_nxt;
  logic [COORD_W-1:0] w_v_nxt;
  vga_beat_t          w_beat_nxt;
  vga_beat_t          r_beat;

  vga_pix_prescaler #(
    .DIV (CLK_DIV)
  ) u_prescaler (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .o_pix_ce (w_pix_ce)
  );

  // Outputs are decoded from the position the counters are about to take, so
  // the registered values line up with the counters one clk after pix_ce.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_h_nxt = r_h + 1'b1;
    w_v_nxt = r_v;
    if (r_h == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end

    w_beat_nxt.x           = w_h_nxt;
    w_beat_nxt.y           = w_v_nxt;
    w_beat_nxt.de          = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
    w_beat_nxt.line_start  = (w_h_nxt == '0);
    w_beat_nxt.frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
    w_beat_nxt.hsync       = ((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    w_beat_nxt.vsync       = ((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  // Reset parks the counters on the last pixel so the first strobe lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h                <= H_LAST;
      r_v                <= V_LAST;
      r_beat.x           <= '0;
      r_beat.y           <= '0;
      r_beat.de          <= 1'b0;
      r_beat.line_start  <= 1'b0;
      r_beat.frame_start <= 1'b0;
      r_beat.hsync       <= ~SYNC_POL;
      r_beat.vsync       <= ~SYNC_POL;
    end else if (w_pix_ce) begin
      r_h    <= w_h_nxt;
      r_v    <= w_v_nxt;
      r_beat <= w_beat_nxt;
    end
  end

  assign pix_ce      = w_pix_ce;
  assign hsync       = r_beat.hsync;
  assign vsync       = r_beat.vsync;
  assign de          = r_beat.de;
  assign x           = r_beat.x;
  assign y           = r_beat.y;
  assign line_start  = r_beat.line_start;
  assign frame_start = r_beat.frame_start;

`ifdef VGA_FRAME_COUNTER_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  // Starts at all-ones so the advance into the first frame reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '1;
    end else if (w_pix_ce && w_beat_nxt.frame_start) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl on a reduced 14x7 raster with CLK_DIV=2.
module tb_vga_timing_ctrl;

  localparam int CLK_DIV = 2;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit POL = 1'b0;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int en_edges = 0;

  vga_timing_ctrl #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pix_ce      (pix_ce),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the raster is a pure function of how many enabled clocks have elapsed since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_edges = 0;
    else if (en) en_edges = en_edges + 1;
  end

  always @(negedge clk) begin : compare
    int k, idx, h, v, fc;
    bit m_de, m_ls, m_fs, m_hs, m_vs;
    k = en_edges / CLK_DIV;
    if (k == 0) begin
      h = 0; v = 0; m_de = 0; m_ls = 0; m_fs = 0; m_hs = ~POL; m_vs = ~POL; fc = 255;
    end else begin
      idx  = k - 1;
      h    = idx % HT;
      v    = (idx / HT) % VT;
      m_de = (h < HA) && (v < VA);
      m_ls = (h == 0);
      m_fs = (h == 0) && (v == 0);
      m_hs = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
      m_vs = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
      fc   = (idx / (HT * VT)) % 256;
    end
`ifndef VGA_FRAME_COUNTER_EN
    fc = 0;
`endif
    check("m_pix_ce", int'(pix_ce), int'(en && (en_edges % CLK_DIV == CLK_DIV - 1)));
    check("m_x", int'(x), h);
    check("m_y", int'(y), v);
    check("m_de", int'(de), int'(m_de));
    check("m_line_start", int'(line_start), int'(m_ls));
    check("m_frame_start", int'(frame_start), int'(m_fs));
    check("m_hsync", int'(hsync), int'(m_hs));
    check("m_vsync", int'(vsync), int'(m_vs));
    check("m_frame_cnt", int'(frame_cnt), fc);
  end

  // Waits (bounded) for the given position; wy < 0 matches any line.
  task automatic wait_pos(input string nm, input int wx, input int wy, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(x) == wx && (wy < 0 || int'(y) == wy)) begin
        found = 1;
        break;
      end
    end
    check({"reach_", nm}, int'(found), 1);
  endtask

  initial begin
    int hs_low, de_low, cyc;
    bit prev;
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x", int'(x), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_de", int'(de), 0);
    check("rst_pix_ce", int'(pix_ce), 0);
    #1 rst_n = 1'b1;

    // First strobe after one enabled clk, first pixel one clk later.
    @(negedge clk);
    check("first_pix_ce", int'(pix_ce), 1);
    check("first_de_pre", int'(de), 0);
    @(negedge clk);
    check("first_x", int'(x), 0);
    check("first_y", int'(y), 0);
    check("first_de", int'(de), 1);
    check("first_frame_start", int'(frame_start), 1);
    check("first_hsync", int'(hsync), 1);
    check("first_vsync", int'(vsync), 1);
`ifdef VGA_FRAME_COUNTER_EN
    check("first_frame_cnt", int'(frame_cnt), 0);
`endif

    // One full line: 28 clks from the first sample of (0,0).
    hs_low = 0; de_low = 0;
    for (int i = 0; i < HT * CLK_DIV; i++) begin
      if (!hsync) begin
        hs_low++;
        check("hsync_pos", int'(x == 10 || x == 11), 1);
      end
      if (!de) de_low++;
      @(negedge clk);
    end
    check("hsync_low_clks", hs_low, 4);
    check("de_low_clks", de_low, 12);
    check("line1_y", int'(y), 1);
    check("line1_x", int'(x), 0);
    check("line1_line_start", int'(line_start), 1);

    wait_pos("y5", 0, 5, 400);
    check("vsync_y5", int'(vsync), 0);
    wait_pos("y6", 0, 6, 60);
    check("vsync_y6", int'(vsync), 1);
    wait_pos("x13y6", 13, 6, 60);
    wait_pos("wrap", 0, 0, 4);
    check("wrap_frame_start", int'(frame_start), 1);

    // frame_start rising-edge period.
    cyc = 0; prev = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_start && !prev) break;
      prev = frame_start;
    end
    check("frame_period", cyc, HT * VT * CLK_DIV);

    // Freeze at x=3.
    wait_pos("x3", 3, -1, 40);
    #1 en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_x", int'(x), 3);
      check("frz_pix_ce", int'(pix_ce), 0);
    end
    #1 en = 1'b1;
    wait_pos("x4", 4, -1, 4);

    // Asynchronous reset mid-frame.
    wait_pos("x6y2", 6, 2, 400);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", int'(x), 0);
    check("arst_y", int'(y), 0);
    check("arst_de", int'(de), 0);
    check("arst_hsync", int'(hsync), 1);
    check("arst_vsync", int'(vsync), 1);
    check("arst_line_start", int'(line_start), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_x", int'(x), 0);
    check("rel_y", int'(y), 0);
    check("rel_frame_start", int'(frame_start), 1);

`ifdef VGA_FRAME_COUNTER_EN
    for (int f = 1; f <= 257; f++) begin
      wait_pos("fc_leave", 1, 0, 4);
      wait_pos("fc_frame", 0, 0, HT * VT * CLK_DIV + 4);
      if (f <= 2 || f >= 255) check("frame_cnt_seq", int'(frame_cnt), f % 256);
    end
`else
    check("frame_cnt_tied", int'(frame_cnt), 0);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
